// File: rtl/nanorv32_ahb_master_bridge_if.sv
// Signal bundle between the nanorv32 data bus, the bridge and the AHB-Lite fabric.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface nanorv32_ahb_master_bridge_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_bytesel;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_bytesel, cpu_din, hrdata, hready, hresp,
        output cpu_dout, cpu_ack, cpu_err, haddr, hwrite, hsize, hburst, hprot,
        output htrans, hmastlock, hwdata
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_bytesel, cpu_din, hrdata, hready, hresp,
        input  cpu_dout, cpu_ack, cpu_err, haddr, hwrite, hsize, hburst, hprot,
        input  htrans, hmastlock, hwdata
    );
endinterface

// File: rtl/nanorv32_ahb_master_bridge.sv
// nanorv32 req/ack data bus to single AHB-Lite master transfers, one outstanding at a time.
// All AHB and CPU-side outputs come straight from registers.
module nanorv32_ahb_master_bridge #(
    parameter logic [3:0] HPROT_VAL     = 4'b0011,
    parameter bit         CHECK_BYTESEL = 1'b1
) (
    input logic                            clk_in,
    input logic                            rst,
    nanorv32_ahb_master_bridge_if.master   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_LERR} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_reg, state_next;
    logic [1:0]  htrans_reg, htrans_next;
    logic [31:0] haddr_reg, haddr_next;
    logic [2:0]  hsize_reg, hsize_next;
    logic        hwrite_reg, hwrite_next;
    logic [31:0] hwdata_reg, hwdata_next;
    logic [31:0] hold_reg, hold_next;
    logic [31:0] dout_reg, dout_next;
    logic        ack_reg, ack_next;
    logic        err_reg, err_next;

    logic        sel_legal;
    logic [2:0]  sel_size;
    logic [1:0]  sel_lo;
    logic        issue;
    logic        go_lerr;
    logic        unused_addr_bits;

    // The lane comes from bytesel, so the CPU's low address bits are not used.
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    always_comb begin
        sel_legal = 1'b1;
        sel_size  = 3'b010;
        sel_lo    = 2'b00;
        case (bus.cpu_bytesel)
            4'b1111: ;
            4'b0011: sel_size = 3'b001;
            4'b1100: begin sel_size = 3'b001; sel_lo = 2'b10; end
            4'b0001: sel_size = 3'b000;
            4'b0010: begin sel_size = 3'b000; sel_lo = 2'b01; end
            4'b0100: begin sel_size = 3'b000; sel_lo = 2'b10; end
            4'b1000: begin sel_size = 3'b000; sel_lo = 2'b11; end
            default: sel_legal = 1'b0;
        endcase
    end

    // A request seen alongside cpu_ack is the tail of the transfer just completed.
    assign issue   = bus.cpu_req && !ack_reg && (sel_legal || !CHECK_BYTESEL);
    assign go_lerr = bus.cpu_req && !ack_reg && !sel_legal && CHECK_BYTESEL;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            htrans_reg <= HTRANS_IDLE;
            haddr_reg  <= 32'h0;
            hsize_reg  <= 3'b010;
            hwrite_reg <= 1'b0;
            hwdata_reg <= 32'h0;
            hold_reg   <= 32'h0;
            dout_reg   <= 32'h0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            htrans_reg <= htrans_next;
            haddr_reg  <= haddr_next;
            hsize_reg  <= hsize_next;
            hwrite_reg <= hwrite_next;
            hwdata_reg <= hwdata_next;
            hold_reg   <= hold_next;
            dout_reg   <= dout_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (issue)        state_next = ST_ADDR;
                else if (go_lerr) state_next = ST_LERR;
            end
            ST_ADDR: if (bus.hready) state_next = ST_DATA;
            ST_DATA: if (bus.hready) state_next = ST_IDLE;
            ST_LERR: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        htrans_next = htrans_reg;
        haddr_next  = haddr_reg;
        hsize_next  = hsize_reg;
        hwrite_next = hwrite_reg;
        hwdata_next = hwdata_reg;
        hold_next   = hold_reg;
        dout_next   = dout_reg;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    haddr_next  = {bus.cpu_addr[31:2], sel_lo};
                    hsize_next  = sel_size;
                    hwrite_next = bus.cpu_wr;
                    htrans_next = HTRANS_NONSEQ;
                    hold_next   = bus.cpu_din;
                end
            end
            ST_ADDR: begin
                if (bus.hready) begin
                    htrans_next = HTRANS_IDLE;
                    if (hwrite_reg) hwdata_next = hold_reg;
                end
            end
            ST_DATA: begin
                // First ERROR cycle has hready low and is simply waited through.
                if (bus.hready) begin
                    ack_next = 1'b1;
                    err_next = bus.hresp;
                    if (!bus.hresp && !hwrite_reg) dout_next = bus.hrdata;
                end
            end
            ST_LERR: begin
                ack_next = 1'b1;
                err_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.htrans    = htrans_reg;
    assign bus.haddr     = haddr_reg;
    assign bus.hsize     = hsize_reg;
    assign bus.hwrite    = hwrite_reg;
    assign bus.hwdata    = hwdata_reg;
    assign bus.hburst    = 3'b000;
    assign bus.hprot     = HPROT_VAL;
    assign bus.hmastlock = 1'b0;
    assign bus.cpu_dout  = dout_reg;
    assign bus.cpu_ack   = ack_reg;
    assign bus.cpu_err   = err_reg;
endmodule
